// File: rtl/csi2_header_ecc_check.sv
// csi2_header_ecc_check
//   Receive-side CSI-2 packet-header ECC checker/corrector. The raw 32-bit header
//   (DI, WC, ECC) is checked against a recomputed 6-bit Hamming parity. Single-bit
//   errors in data or parity are corrected. Multi-bit errors are flagged and the
//   raw fields are passed through unchanged. Two-stage valid/ready pipeline:
//     stage 1 registers data and syndrome, stage 2 registers corrected fields/flags.
//   Optional macro CSI2_HDR_ECC_STATS_EN adds saturating error counters. Without it
//   the counter outputs are tied to zero and clr_stats is ignored.

module csi2_header_ecc_check #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_hdr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_vc,
  output logic [5:0]       m_dt,
  output logic [15:0]      m_wc,
  output logic             m_corrected,
  output logic             m_err_uncorr,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  // Data-bit membership of each parity bit, element [k] covers P[k].
  // Bit i of a mask is set when D[i] contributes to that parity bit.
  localparam logic [5:0][23:0] PMASK = {
    24'hEFFC00,   // P5
    24'hDF03F0,   // P4
    24'hB8E38E,   // P3
    24'h749A6D,   // P2
    24'hF2555B,   // P1
    24'hF12CB7    // P0
  };

  // ---------------------------------------------------------------------------
  // Input-side parity and syndrome (combinational, registered by stage 1)
  // ---------------------------------------------------------------------------
  logic [23:0] in_d;
  logic [5:0]  in_par;
  logic [5:0]  in_syn;

  assign in_d = s_hdr[23:0];

  genvar gk;
  generate
    for (gk = 0; gk < 6; gk++) begin : g_par
      assign in_par[gk] = ^(in_d & PMASK[gk]);
    end
  endgenerate

  assign in_syn = in_par ^ s_hdr[29:24];

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic        s1_full_reg;
  logic [23:0] s1_d_reg;
  logic [5:0]  s1_syn_reg;

  logic        m_valid_reg;
  logic [1:0]  m_vc_reg;
  logic [5:0]  m_dt_reg;
  logic [15:0] m_wc_reg;
  logic        m_corr_reg;
  logic        m_uncorr_reg;

  // Stage 2 may load when empty or when its header leaves this cycle; stage 1
  // advances when it holds a header and stage 2 can take it.
  logic s2_load;
  logic s1_adv;

  assign s2_load = !m_valid_reg || m_ready;
  assign s1_adv  = s1_full_reg && s2_load;
  assign s_ready = !s1_full_reg || s1_adv;

  // ---------------------------------------------------------------------------
  // Syndrome decode on the stage-1 contents
  // ---------------------------------------------------------------------------
  // Each data column has weight >= 3, so a column hit never aliases a one-hot
  // (parity-bit) syndrome, and the columns are distinct so at most one bit hits.
  logic [23:0] col_hit;
  logic        syn_onehot;
  logic        corr_next;
  logic        uncorr_next;
  logic [23:0] d_fix;

  genvar gi;
  generate
    for (gi = 0; gi < 24; gi++) begin : g_col
      localparam logic [5:0] COL = {PMASK[5][gi], PMASK[4][gi], PMASK[3][gi],
                                    PMASK[2][gi], PMASK[1][gi], PMASK[0][gi]};
      assign col_hit[gi] = (s1_syn_reg == COL);
    end
  endgenerate

  assign syn_onehot  = $onehot(s1_syn_reg);
  assign corr_next   = (|col_hit) || syn_onehot;
  assign uncorr_next = (s1_syn_reg != 6'd0) && !corr_next;
  assign d_fix       = s1_d_reg ^ col_hit;

  // Stage 1: capture raw data and syndrome whenever a new header is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_reg <= 1'b0;
      s1_d_reg    <= '0;
      s1_syn_reg  <= '0;
    end else if (s_ready) begin
      s1_full_reg <= s_valid;
      if (s_valid) begin
        s1_d_reg   <= in_d;
        s1_syn_reg <= in_syn;
      end
    end
  end

  // Stage 2: register corrected fields and flags; hold them while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg  <= 1'b0;
      m_vc_reg     <= '0;
      m_dt_reg     <= '0;
      m_wc_reg     <= '0;
      m_corr_reg   <= 1'b0;
      m_uncorr_reg <= 1'b0;
    end else if (s2_load) begin
      m_valid_reg <= s1_full_reg;
      if (s1_full_reg) begin
        m_vc_reg     <= d_fix[7:6];
        m_dt_reg     <= d_fix[5:0];
        m_wc_reg     <= d_fix[23:8];
        m_corr_reg   <= corr_next;
        m_uncorr_reg <= uncorr_next;
      end
    end
  end

  assign m_valid      = m_valid_reg;
  assign m_vc         = m_vc_reg;
  assign m_dt         = m_dt_reg;
  assign m_wc         = m_wc_reg;
  assign m_corrected  = m_corr_reg;
  assign m_err_uncorr = m_uncorr_reg;

  // ---------------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------------
`ifdef CSI2_HDR_ECC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_corr_reg;
  logic [CNT_W-1:0] cnt_uncorr_reg;
  logic             m_fire;
  logic             unused_bits;

  assign m_fire      = m_valid_reg && m_ready;
  assign unused_bits = ^s_hdr[31:30];

  // Count flagged headers as they leave; clear wins over increment, saturate at max.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
    end else if (m_fire) begin
      if (m_corr_reg && (cnt_corr_reg != '1))
        cnt_corr_reg <= cnt_corr_reg + CNT_ONE;
      if (m_uncorr_reg && (cnt_uncorr_reg != '1))
        cnt_uncorr_reg <= cnt_uncorr_reg + CNT_ONE;
    end
  end

  assign cnt_corr   = cnt_corr_reg;
  assign cnt_uncorr = cnt_uncorr_reg;
`else
  logic unused_bits;

  assign unused_bits = ^{s_hdr[31:30], clr_stats};
  assign cnt_corr    = '0;
  assign cnt_uncorr  = '0;
`endif

endmodule

// File: tb/tb_csi2_header_ecc_check.sv
// tb_csi2_header_ecc_check
//   Table of known headers plus hand-written handshake/reset/statistics sequences
//   and a randomized stream checked against a behavioural ECC model.

module tb_csi2_header_ecc_check;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_hdr;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    m_vc;
  logic [5:0]    m_dt;
  logic [15:0]   m_wc;
  logic          m_corrected;
  logic          m_err_uncorr;
  logic          clr_stats;
  logic [CW-1:0] cnt_corr;
  logic [CW-1:0] cnt_uncorr;

  int total = 0;
  int bad   = 0;
  int mc_corr   = 0;
  int mc_uncorr = 0;

  csi2_header_ecc_check #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_hdr(s_hdr),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_vc(m_vc), .m_dt(m_dt), .m_wc(m_wc),
    .m_corrected(m_corrected), .m_err_uncorr(m_err_uncorr),
    .clr_stats(clr_stats), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    logic [25:0] exp;   // {vc, dt, wc, corrected, uncorr}
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] pack_out();
    return {m_vc, m_dt, m_wc, m_corrected, m_err_uncorr};
  endfunction

  // Parity membership as listed for the CSI-2 header Hamming code.
  function automatic bit in_p(input int k, input int i);
    case (k)
      5:       return i inside {[10:19], 21, 22, 23};
      4:       return i inside {[4:9], [16:20], 22, 23};
      3:       return i inside {[1:3], [7:9], [13:15], [19:21], 23};
      2:       return i inside {0, 2, 3, 5, 6, 9, 11, 12, 15, 18, [20:22]};
      1:       return i inside {0, 1, 3, 4, 6, 8, 10, 12, 14, 17, [20:23]};
      default: return i inside {0, 1, 2, 4, 5, 7, 10, 11, 13, 16, [20:23]};
    endcase
  endfunction

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] p = '0;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 24; i++)
        if (in_p(k, i) && d[i]) p[k] = ~p[k];
    return p;
  endfunction

  // Reference: no error, parity-bit error, or the unique data bit whose flip makes
  // the received ECC consistent; anything else is uncorrectable.
  function automatic logic [25:0] model(input logic [31:0] h);
    logic [23:0] d = h[23:0];
    logic [5:0]  e = h[29:24];
    logic [5:0]  s = ecc_of(d) ^ e;
    if (s == 6'd0) return {d[7:0], d[23:8], 2'b00};
    if ($onehot(s)) return {d[7:0], d[23:8], 2'b10};
    for (int i = 0; i < 24; i++) begin
      logic [23:0] t = d ^ (24'd1 << i);
      if (ecc_of(t) == e) return {t[7:0], t[23:8], 2'b10};
    end
    return {d[7:0], d[23:8], 2'b01};
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef CSI2_HDR_ECC_STATS_EN
    if (n > (1 << CW) - 1) return '1;
    return CW'(n);
`else
    return (n < 0) ? '1 : '0;
`endif
  endfunction

  function automatic logic [31:0] gen_hdr();
    logic [23:0] d = 24'($urandom);
    logic [5:0]  e = ecc_of(d);
    int          r = $urandom_range(0, 9);
    int          a = $urandom_range(0, 23);
    int          b = (a + $urandom_range(1, 23)) % 24;
    case (r)
      4, 5:    d = d ^ (24'd1 << a);
      6:       e = e ^ (6'd1 << $urandom_range(0, 5));
      7:       d = d ^ (24'd1 << a) ^ (24'd1 << b);
      8:       e = 6'($urandom);
      9:       begin d = d ^ (24'd1 << a); e = e ^ (6'd1 << $urandom_range(0, 5)); end
      default: ;
    endcase
    return {2'($urandom), e, d};
  endfunction

  // Send one header with m_ready high; return the output seen and its latency.
  task automatic send_get(input logic [31:0] h, output logic [25:0] got, output int lat);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_hdr = h; m_ready = 1'b1;
    #1;
    while (!s_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin @(negedge clk); lat++; end
    got = pack_out();
    @(posedge clk);
  endtask

  // Stream nhdr headers. mode 0: back-to-back, m_ready 1010...; mode 1: random.
  task automatic run_stream(input int nhdr, input int mode, input int max_cycles);
    logic [25:0] exp_q[$];
    logic [26:0] held = '0;
    bit          prev_stall = 0;
    bit          hold_s = 0;
    int          sent = 0, recv = 0;
    for (int cyc = 0; cyc < max_cycles && recv < nhdr; cyc++) begin
      @(negedge clk);
      if (!hold_s) begin
        if (sent < nhdr && (mode == 0 || $urandom_range(0, 3) != 0)) begin
          s_valid = 1'b1; s_hdr = gen_hdr();
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) chk("stall_hold", 64'({m_valid, pack_out()}), 64'(held));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("stream_extra", 64'(1), 64'(0));
        else begin
          logic [25:0] e = exp_q.pop_front();
          chk("stream_out", 64'(pack_out()), 64'(e));
          if (e[1]) mc_corr++;
          if (e[0]) mc_uncorr++;
        end
        recv++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(model(s_hdr));
        sent++;
      end
      hold_s     = s_valid && !s_ready;
      prev_stall = m_valid && !m_ready;
      held       = {m_valid, pack_out()};
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1;
    chk("stream_count", 64'(recv), 64'(nhdr));
  endtask

  initial begin
    vec_t        vecs[9];
    logic [25:0] got;
    int          lat;
    int          n;
    bit          seen;

    vecs[0] = '{32'h180F002B, {2'd0, 6'h2B, 16'h0F00, 2'b00}};  // clean
    vecs[1] = '{32'h180F002A, {2'd0, 6'h2B, 16'h0F00, 2'b10}};  // D0 flipped
    vecs[2] = '{32'h188F002B, {2'd0, 6'h2B, 16'h0F00, 2'b10}};  // D23 flipped
    vecs[3] = '{32'h080F002B, {2'd0, 6'h2B, 16'h0F00, 2'b10}};  // ECC bit 4 flipped
    vecs[4] = '{32'h180F0028, {2'd0, 6'h28, 16'h0F00, 2'b01}};  // D0,D1 flipped
    vecs[5] = '{32'hD80F002B, {2'd0, 6'h2B, 16'h0F00, 2'b00}};  // ECC[7:6] ignored
    vecs[6] = '{32'h00000000, {2'd0, 6'h00, 16'h0000, 2'b00}};  // all zero
    vecs[7] = '{32'h0F0000C0, {2'd3, 6'h00, 16'h0000, 2'b00}};  // VC=3 clean
    vecs[8] = '{32'h0F000080, {2'd3, 6'h00, 16'h0000, 2'b10}};  // D6 flipped

    rst = 1'b1; s_valid = 1'b0; s_hdr = '0; m_ready = 1'b0; clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_outputs", 64'(pack_out()), 64'(0));
    chk("rst_counters", 64'({cnt_corr, cnt_uncorr}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", 64'(s_ready), 64'(1));

    // Known-answer table
    foreach (vecs[i]) begin
      send_get(vecs[i].hdr, got, lat);
      chk($sformatf("vec%0d", i), 64'(got), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(2));
      if (vecs[i].exp[1]) mc_corr++;
      if (vecs[i].exp[0]) mc_uncorr++;
      $display("vec %0d hdr=%h out=%h lat=%0d", i, vecs[i].hdr, got, lat);
    end
    @(negedge clk);
    chk("cnt_corr_table", 64'(cnt_corr), 64'(exp_cnt(mc_corr)));
    chk("cnt_uncorr_table", 64'(cnt_uncorr), 64'(exp_cnt(mc_uncorr)));

    // Clear, then clear on the same cycle as a corrected header leaves.
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0; mc_corr = 0; mc_uncorr = 0;
    chk("clr_counters", 64'({cnt_corr, cnt_uncorr}), 64'(0));
    m_ready = 1'b0; s_valid = 1'b1; s_hdr = 32'h180F002A;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    chk("clr_hdr_ready", 64'(m_valid), 64'(1));
    m_ready = 1'b1; clr_stats = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_stats = 1'b0;
    chk("clr_priority", 64'(cnt_corr), 64'(0));
    chk("clr_hdr_gone", 64'(m_valid), 64'(0));
    $display("clr_stats with corrected transfer: cnt_corr=%0d", cnt_corr);

    // Back-to-back stream with alternating m_ready, then a long random stream.
    run_stream(8, 0, 100);
    $display("stream8 done total=%0d", total);
    run_stream(300, 1, 5000);
    $display("random stream done total=%0d", total);
    @(negedge clk);
    chk("cnt_corr_stream", 64'(cnt_corr), 64'(exp_cnt(mc_corr)));
    chk("cnt_uncorr_stream", 64'(cnt_uncorr), 64'(exp_cnt(mc_uncorr)));

    // Reset with two headers in flight.
    m_ready = 1'b0; s_valid = 1'b1; s_hdr = 32'h180F002B;
    @(posedge clk);
    @(negedge clk);
    s_hdr = 32'h0F0000C0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("inflight_before_rst", 64'(m_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_m_valid", 64'(m_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk("rst_mid_no_output", 64'(seen), 64'(0));
    chk("rst_mid_s_ready", 64'(s_ready), 64'(1));
    chk("rst_mid_counters", 64'({cnt_corr, cnt_uncorr}), 64'(0));
    $display("mid-flight reset: output seen=%0d", seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
